// File: rtl/player_input_conditioner.sv
// -----------------------------------------------------------------------------
// player_input_conditioner
//
// Conditions one player's seven raw push-buttons for the game core:
//   2-flop synchronizer -> per-bit counter debounce -> optional conflict mask
//   -> registered level / rising-edge outputs, plus a rate-limited attack
//   strobe driven by an IDLE/FIRE/COOLDOWN state machine.
//
// Parameters
//   DB_CYCLES  debounce length in clk cycles (2 .. 2^20-1)
//   CD_CYCLES  attack cooldown length in clk cycles (2 .. 2^25-1)
//
// Ports
//   clk            in   system clock, single domain
//   reset          in   asynchronous active-high reset (released synchronously
//                       at its source)
//   enable         in   gameplay enable; low forces all outputs to 0 and the
//                       attack FSM to IDLE while debouncing keeps tracking
//   raw_btn[6:0]   in   raw buttons: [0] center [1] left [2] right [3] up
//                       [4] down [5] attack [6] shield
//   btn_level[6:0] out  debounced (and optionally masked) levels
//   btn_rise[6:0]  out  one-cycle pulse on each 0->1 transition of btn_level
//   attack_fire    out  one-cycle attack strobe
//   cooldown_busy  out  high while the attack cooldown runs
//
// Build option
//   PLAYER_LR_CONFLICT_MASK_EN : when defined, left+right held together both
//   read as 0, and likewise up+down. Rising edges are taken after masking.
// -----------------------------------------------------------------------------
module player_input_conditioner #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CD_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] raw_btn,
    output logic [6:0] btn_level,
    output logic [6:0] btn_rise,
    output logic       attack_fire,
    output logic       cooldown_busy
);

    // The counter value on which the stable level flips: the next increment
    // would make it DB_CYCLES-1, so the update happens instead of that step.
    localparam logic [19:0] DB_THR  = 20'(DB_CYCLES - 2);
    localparam logic [24:0] CD_LAST = 25'(CD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FIRE     = 2'b01,
        ST_COOLDOWN = 2'b10
    } attack_state_t;

    logic [6:0]    r_sync1;
    logic [6:0]    r_sync2;
    logic [6:0]    r_stable;
    logic [19:0]   r_db_cnt [7];
    logic [6:0]    r_track;
    logic [6:0]    r_level;
    logic [6:0]    r_rise;
    attack_state_t r_state;
    logic [24:0]   r_cd_cnt;
    logic          r_attack_fire;
    logic          r_cooldown_busy;
    logic [6:0]    w_masked;

    // Suppress opposing direction pairs when the conflict mask is built in.
    function automatic logic [6:0] conflict_mask(input logic [6:0] lvl);
        logic [6:0] m;
        m = lvl;
`ifdef PLAYER_LR_CONFLICT_MASK_EN
        if (lvl[1] && lvl[2]) begin
            m[2:1] = 2'b00;
        end else begin
            m[2:1] = lvl[2:1];
        end
        if (lvl[3] && lvl[4]) begin
            m[4:3] = 2'b00;
        end else begin
            m[4:3] = lvl[4:3];
        end
`endif
        return m;
    endfunction

    // Two-flop synchronizer on every raw button bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 7'h00;
            r_sync2 <= 7'h00;
        end else begin
            r_sync1 <= raw_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: count while the input disagrees with the stable level,
    // flip the level at the threshold; any return to the stable level restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 7'h00;
            for (int i = 0; i < 7; i++) begin
                r_db_cnt[i] <= 20'd0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_db_cnt[i] <= 20'd0;
                end else if (r_db_cnt[i] >= DB_THR) begin
                    r_stable[i] <= r_sync2[i];
                    r_db_cnt[i] <= 20'd0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // Mask is applied before edge detection so a masked pair never pulses.
    always_comb begin
        w_masked = conflict_mask(r_stable);
    end

    // Output level and rise registers. r_track follows the masked level even
    // while disabled, so resuming with a button already held gives no pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_track <= 7'h00;
            r_level <= 7'h00;
            r_rise  <= 7'h00;
        end else begin
            r_track <= w_masked;
            if (enable) begin
                r_level <= w_masked;
                r_rise  <= w_masked & ~r_track;
            end else begin
                r_level <= 7'h00;
                r_rise  <= 7'h00;
            end
        end
    end

    // Attack FSM: a registered attack rise fires one strobe, then the cooldown
    // counter runs 0..CD_CYCLES-1 with rises ignored (never queued).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cd_cnt        <= 25'd0;
            r_attack_fire   <= 1'b0;
            r_cooldown_busy <= 1'b0;
        end else if (!enable) begin
            r_state         <= ST_IDLE;
            r_cd_cnt        <= 25'd0;
            r_attack_fire   <= 1'b0;
            r_cooldown_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cd_cnt        <= 25'd0;
                    r_cooldown_busy <= 1'b0;
                    if (r_rise[5]) begin
                        r_state       <= ST_FIRE;
                        r_attack_fire <= 1'b1;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_attack_fire <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    r_state         <= ST_COOLDOWN;
                    r_cd_cnt        <= 25'd0;
                    r_attack_fire   <= 1'b0;
                    r_cooldown_busy <= 1'b1;
                end
                ST_COOLDOWN: begin
                    r_attack_fire <= 1'b0;
                    if (r_cd_cnt == CD_LAST) begin
                        r_state         <= ST_IDLE;
                        r_cd_cnt        <= 25'd0;
                        r_cooldown_busy <= 1'b0;
                    end else begin
                        r_state         <= ST_COOLDOWN;
                        r_cd_cnt        <= r_cd_cnt + 25'd1;
                        r_cooldown_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state         <= ST_IDLE;
                    r_cd_cnt        <= 25'd0;
                    r_attack_fire   <= 1'b0;
                    r_cooldown_busy <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level     = r_level;
    assign btn_rise      = r_rise;
    assign attack_fire   = r_attack_fire;
    assign cooldown_busy = r_cooldown_busy;

endmodule
